rx_framing_decoder: RTL and testbench



---
 rtl/rx_framing_decoder.sv | 127 ++++++++++++
 tb/tb_rx_framing_decoder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_framing_decoder.sv
// 8b/10b receive framing decoder: turns a 64-byte symbol beat into per-byte TLP/DLLP markers,
// tracking framing state across beats and counting beats that contain framing violations.
module rx_framing_decoder (
   input  logic         clk,
   input  logic         reset,
   input  logic         in_valid,
   input  logic [511:0] in_data,
   input  logic [63:0]  in_datak,
   input  logic         err_clr,
   output logic [511:0] packetData,
   output logic [63:0]  packetValid,
   output logic [63:0]  tlpstart,
   output logic [63:0]  dllpstart,
   output logic [63:0]  tlpend,
   output logic [63:0]  dllpend,
   output logic [63:0]  edb,
   output logic         framing_error,
   output logic [15:0]  err_count
);

   localparam logic [7:0] SymStp = 8'hFB;
   localparam logic [7:0] SymSdp = 8'h5C;
   localparam logic [7:0] SymEnd = 8'hFD;
   localparam logic [7:0] SymEdb = 8'hFE;
   localparam logic [2:0] DllpLen = 3'd6;

   typedef enum logic [1:0] {StIdle, StTlp, StDllp} state_e;

   state_e      state_q, state_d;
   logic [2:0]  dcnt_q, dcnt_d;
   logic [63:0] pv_d, ts_d, ds_d, te_d, de_d, edb_d;
   logic        viol_d;
   logic [7:0]  sym;
   logic        symk;

   // Walk the beat byte by byte; state_d/dcnt_d carry the running framing context.
   always_comb begin
      state_d = state_q;
      dcnt_d  = dcnt_q;
      pv_d    = '0;
      ts_d    = '0;
      ds_d    = '0;
      te_d    = '0;
      de_d    = '0;
      edb_d   = '0;
      viol_d  = 1'b0;
      sym     = '0;
      symk    = 1'b0;
      if (in_valid) begin
         for (int i = 0; i < 64; i++) begin
            sym  = in_data[8*i +: 8];
            symk = in_datak[i];
            case (state_d)
               StIdle: begin
                  if (symk && sym == SymStp) begin
                     ts_d[i] = 1'b1;
                     state_d = StTlp;
                  end else if (symk && sym == SymSdp) begin
                     ds_d[i] = 1'b1;
                     state_d = StDllp;
                     dcnt_d  = '0;
                  end else if (!symk) begin
                     viol_d = 1'b1;
                  end
               end
               StTlp: begin
                  if (!symk) begin
                     pv_d[i] = 1'b1;
                  end else if (sym == SymEnd) begin
                     te_d[i] = 1'b1;
                     state_d = StIdle;
                  end else begin
                     // Unexpected K inside a TLP is nullified rather than restarted.
                     edb_d[i] = 1'b1;
                     viol_d   = viol_d | (sym != SymEdb);
                     state_d  = StIdle;
                  end
               end
               StDllp: begin
                  if (!symk && dcnt_d < DllpLen) begin
                     pv_d[i] = 1'b1;
                     dcnt_d  = dcnt_d + 3'd1;
                  end else begin
                     de_d[i] = 1'b1;
                     viol_d  = viol_d | !(symk && sym == SymEnd && dcnt_d == DllpLen);
                     state_d = StIdle;
                  end
               end
               default: state_d = StIdle;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= StIdle;
         dcnt_q        <= '0;
         packetData    <= '0;
         packetValid   <= '0;
         tlpstart      <= '0;
         dllpstart     <= '0;
         tlpend        <= '0;
         dllpend       <= '0;
         edb           <= '0;
         framing_error <= 1'b0;
         err_count     <= '0;
      end else begin
         state_q       <= state_d;
         dcnt_q        <= dcnt_d;
         packetData    <= in_valid ? in_data : '0;
         packetValid   <= pv_d;
         tlpstart      <= ts_d;
         dllpstart     <= ds_d;
         tlpend        <= te_d;
         dllpend       <= de_d;
         edb           <= edb_d;
         framing_error <= viol_d;
         if (err_clr) begin
            err_count <= '0;
         end else if (viol_d && err_count != 16'hFFFF) begin
            err_count <= err_count + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_rx_framing_decoder.sv
// Bench for rx_framing_decoder: directed framing scenarios plus randomized beats checked
// against a byte-stream reference model.
module tb_rx_framing_decoder;

   logic         clk = 1'b0;
   logic         reset;
   logic         in_valid;
   logic [511:0] in_data;
   logic [63:0]  in_datak;
   logic         err_clr;
   logic [511:0] packetData;
   logic [63:0]  packetValid, tlpstart, dllpstart, tlpend, dllpend, edb;
   logic         framing_error;
   logic [15:0]  err_count;

   always #5 clk = ~clk;

   rx_framing_decoder dut (
      .clk          (clk),
      .reset        (reset),
      .in_valid     (in_valid),
      .in_data      (in_data),
      .in_datak     (in_datak),
      .err_clr      (err_clr),
      .packetData   (packetData),
      .packetValid  (packetValid),
      .tlpstart     (tlpstart),
      .dllpstart    (dllpstart),
      .tlpend       (tlpend),
      .dllpend      (dllpend),
      .edb          (edb),
      .framing_error(framing_error),
      .err_count    (err_count)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // beat under construction
   logic [7:0] bv[64];
   logic       bk[64];

   // reference model context: kind 0 = outside packet, 1 = in TLP, 2 = in DLLP
   int m_kind = 0;
   int m_seen = 0;
   int m_cnt  = 0;

   logic [511:0] e_data;
   logic [63:0]  e_pv, e_ts, e_ds, e_te, e_de, e_edb;
   logic         e_fe;
   logic [15:0]  e_cnt;

   task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string t);
      check({t, "/data"}, packetData, e_data);
      check({t, "/pv"}, {448'd0, packetValid}, {448'd0, e_pv});
      check({t, "/tlpstart"}, {448'd0, tlpstart}, {448'd0, e_ts});
      check({t, "/dllpstart"}, {448'd0, dllpstart}, {448'd0, e_ds});
      check({t, "/tlpend"}, {448'd0, tlpend}, {448'd0, e_te});
      check({t, "/dllpend"}, {448'd0, dllpend}, {448'd0, e_de});
      check({t, "/edb"}, {448'd0, edb}, {448'd0, e_edb});
      check({t, "/ferr"}, {511'd0, framing_error}, {511'd0, e_fe});
      check({t, "/errcnt"}, {496'd0, err_count}, {496'd0, e_cnt});
   endtask

   task automatic fill_idle();
      for (int i = 0; i < 64; i++) begin
         bv[i] = 8'h7C;
         bk[i] = 1'b1;
      end
   endtask

   task automatic put(input int i, input logic [7:0] v, input logic k);
      bv[i] = v;
      bk[i] = k;
   endtask

   // 0 D, 1 STP, 2 SDP, 3 END, 4 EDB, 5 other K
   function automatic int sym_class(input logic [7:0] v, input logic k);
      if (!k) return 0;
      case (v)
         8'hFB:   return 1;
         8'h5C:   return 2;
         8'hFD:   return 3;
         8'hFE:   return 4;
         default: return 5;
      endcase
   endfunction

   task automatic model_reset();
      m_kind = 0;
      m_seen = 0;
      m_cnt  = 0;
      e_data = '0;
      {e_pv, e_ts, e_ds, e_te, e_de, e_edb} = '0;
      e_fe  = 1'b0;
      e_cnt = '0;
   endtask

   task automatic model_beat();
      int c;
      {e_pv, e_ts, e_ds, e_te, e_de, e_edb} = '0;
      e_fe   = 1'b0;
      e_data = in_valid ? in_data : '0;
      if (in_valid) begin
         for (int i = 0; i < 64; i++) begin
            c = sym_class(in_data[8*i +: 8], in_datak[i]);
            if (m_kind == 0) begin
               if (c == 1) begin e_ts[i] = 1'b1; m_kind = 1; end
               else if (c == 2) begin e_ds[i] = 1'b1; m_kind = 2; m_seen = 0; end
               else if (c == 0) e_fe = 1'b1;
            end else if (m_kind == 1) begin
               if (c == 0) e_pv[i] = 1'b1;
               else if (c == 3) begin e_te[i] = 1'b1; m_kind = 0; end
               else begin
                  e_edb[i] = 1'b1;
                  if (c != 4) e_fe = 1'b1;
                  m_kind = 0;
               end
            end else begin
               if (c == 0 && m_seen < 6) begin e_pv[i] = 1'b1; m_seen++; end
               else begin
                  e_de[i] = 1'b1;
                  if (!(c == 3 && m_seen == 6)) e_fe = 1'b1;
                  m_kind = 0;
               end
            end
         end
      end
      if (err_clr) m_cnt = 0;
      else if (e_fe && m_cnt < 65535) m_cnt++;
      e_cnt = m_cnt[15:0];
   endtask

   task automatic step(input string t, input logic chk);
      for (int i = 0; i < 64; i++) begin
         in_data[8*i +: 8] = bv[i];
         in_datak[i]       = bk[i];
      end
      model_beat();
      @(posedge clk);
      #1;
      if (chk) check_all(t);
   endtask

   initial begin
      reset    = 1'b0;
      in_valid = 1'b0;
      in_data  = '0;
      in_datak = '0;
      err_clr  = 1'b0;
      model_reset();
      #12;
      check_all("reset");
      reset = 1'b1;
      @(posedge clk);
      #1;

      // TLP within one beat
      in_valid = 1'b1;
      fill_idle();
      put(0, 8'hFB, 1'b1);
      for (int i = 1; i <= 20; i++) put(i, 8'(i), 1'b0);
      put(21, 8'hFD, 1'b1);
      step("tlp1", 1'b1);
      check("tlp1_ts_const", {448'd0, tlpstart}, {448'd0, 64'h1});
      check("tlp1_pv_const", {448'd0, packetValid}, {448'd0, 64'h1F_FFFE});
      check("tlp1_te_const", {448'd0, tlpend}, {448'd0, 64'h20_0000});

      // DLLP spanning two beats
      fill_idle();
      put(60, 8'h5C, 1'b1);
      for (int i = 61; i < 64; i++) put(i, 8'hA0 + 8'(i), 1'b0);
      step("dllp_a", 1'b1);
      check("dllp_ds_const", {448'd0, dllpstart}, {448'd0, 64'h1000_0000_0000_0000});
      fill_idle();
      for (int i = 0; i < 3; i++) put(i, 8'h30 + 8'(i), 1'b0);
      put(3, 8'hFD, 1'b1);
      step("dllp_b", 1'b1);
      check("dllp_de_const", {448'd0, dllpend}, {448'd0, 64'h8});
      check("dllp_pv_const", {448'd0, packetValid}, {448'd0, 64'h7});

      // Nullified TLP
      fill_idle();
      put(5, 8'hFB, 1'b1);
      for (int i = 6; i < 10; i++) put(i, 8'h55, 1'b0);
      put(10, 8'hFE, 1'b1);
      step("nullify", 1'b1);
      check("nullify_edb_const", {448'd0, edb}, {448'd0, 64'h400});

      // Violations: STP inside TLP, then short DLLP
      fill_idle();
      put(0, 8'hFB, 1'b1);
      put(1, 8'h11, 1'b0);
      put(2, 8'hFB, 1'b1);
      step("viol_stp", 1'b1);
      check("viol_stp_edb_const", {448'd0, edb}, {448'd0, 64'h4});
      fill_idle();
      put(0, 8'h5C, 1'b1);
      for (int i = 1; i <= 4; i++) put(i, 8'h22, 1'b0);
      put(5, 8'hFD, 1'b1);
      step("viol_dllp", 1'b1);
      check("viol_cnt_const", {496'd0, err_count}, {496'd0, 16'd2});

      // Flow control gap mid-TLP
      fill_idle();
      put(60, 8'hFB, 1'b1);
      for (int i = 61; i < 64; i++) put(i, 8'h44, 1'b0);
      step("gap_start", 1'b1);
      in_valid = 1'b0;
      for (int g = 0; g < 3; g++) begin
         for (int i = 0; i < 64; i++) put(i, 8'($urandom), 1'($urandom));
         step("gap_idle", 1'b1);
      end
      in_valid = 1'b1;
      fill_idle();
      for (int i = 0; i < 10; i++) put(i, 8'h66, 1'b0);
      put(10, 8'hFD, 1'b1);
      step("gap_resume", 1'b1);

      // err_clr beats a simultaneous increment
      fill_idle();
      put(7, 8'h01, 1'b0);
      err_clr = 1'b1;
      step("errclr", 1'b1);
      err_clr = 1'b0;

      // Saturate err_count
      while (m_cnt < 65535) step("sat_fill", 1'b0);
      check("sat_reached", {496'd0, err_count}, {496'd0, 16'hFFFF});
      step("sat_hold", 1'b1);

      // Async reset mid-DLLP with three payload bytes seen
      fill_idle();
      put(60, 8'h5C, 1'b1);
      for (int i = 61; i < 64; i++) put(i, 8'h77, 1'b0);
      step("rst_pre", 1'b1);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      check_all("rst_async");
      @(posedge clk);
      #2;
      reset = 1'b1;
      for (int i = 0; i < 64; i++) put(i, 8'h5A, 1'b0);
      step("rst_post", 1'b1);
      check("rst_post_pv_const", {448'd0, packetValid}, {448'd0, 64'h0});

      // Randomized beats
      for (int n = 0; n < 300; n++) begin
         for (int i = 0; i < 64; i++) begin
            int r;
            logic [7:0] v;
            r = $urandom_range(99);
            v = 8'($urandom);
            if (r < 60) put(i, v, 1'b0);
            else if (r < 66) put(i, 8'hFB, 1'b1);
            else if (r < 72) put(i, 8'h5C, 1'b1);
            else if (r < 82) put(i, 8'hFD, 1'b1);
            else if (r < 85) put(i, 8'hFE, 1'b1);
            else if (v == 8'hFB || v == 8'h5C || v == 8'hFD || v == 8'hFE) put(i, 8'h7C, 1'b1);
            else put(i, v, 1'b1);
         end
         in_valid = ($urandom_range(9) != 0);
         err_clr  = ($urandom_range(31) == 0);
         step("rand", 1'b1);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
